// File: rtl/sel_mux_pkg.sv
// Shared types and default parameter values for the project selection mux.
package sel_mux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GUARD  = 2'd1,
    PRST   = 2'd2,
    ACTIVE = 2'd3
  } state_t;

  localparam int DEF_NUM_PROJ  = 24;
  localparam int DEF_ADDR_W    = 5;
  localparam int DEF_IW_W      = 18;
  localparam int DEF_OW_W      = 24;
  localparam int DEF_GUARD_CYC = 2;
  localparam int DEF_RST_CYC   = 4;

endpackage

// File: rtl/sel_mux_seq.sv
// Selection sequencer: latches the requested address and walks it through
// the all-off guard window and the project reset window before going live.
module sel_mux_seq
  import sel_mux_pkg::*;
#(
  parameter int NUM_PROJ  = DEF_NUM_PROJ,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int GUARD_CYC = DEF_GUARD_CYC,
  parameter int RST_CYC   = DEF_RST_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              sel_load,
  input  logic [ADDR_W-1:0] addr,
  output state_t            state,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              busy,
  output logic              sel_valid
);

  localparam int CNT_MAX = (GUARD_CYC > RST_CYC) ? GUARD_CYC : RST_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0]  GUARD_LOAD   = CNT_W'(GUARD_CYC - 1);
  localparam logic [CNT_W-1:0]  RST_LOAD     = CNT_W'(RST_CYC - 1);
  localparam logic [ADDR_W:0]   NUM_PROJ_LIM = (ADDR_W + 1)'(NUM_PROJ);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cur_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_addr_q <= cur_addr_d;
    end
  end

  // Dropping ena abandons any selection; cur_addr keeps the last request.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_addr_d = cur_addr_q;
    if (!ena) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE, ACTIVE: begin
          if (sel_load) begin
            state_d    = GUARD;
            cnt_d      = GUARD_LOAD;
            cur_addr_d = addr;
          end
        end
        GUARD: begin
          if (cnt_q == '0) begin
            if ({1'b0, cur_addr_q} < NUM_PROJ_LIM) begin
              state_d = PRST;
              cnt_d   = RST_LOAD;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        PRST: begin
          if (cnt_q == '0) begin
            state_d = ACTIVE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign state     = state_q;
  assign cur_addr  = cur_addr_q;
  assign busy      = (state_q == GUARD) || (state_q == PRST);
  assign sel_valid = (state_q == ACTIVE);

endmodule

// File: rtl/sel_mux.sv
// Project selection mux: steers enable, reset and the shared input word to
// one project slot and registers that slot's output word back.
module sel_mux
  import sel_mux_pkg::*;
#(
  parameter int NUM_PROJ  = DEF_NUM_PROJ,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int IW_W      = DEF_IW_W,
  parameter int OW_W      = DEF_OW_W,
  parameter int GUARD_CYC = DEF_GUARD_CYC,
  parameter int RST_CYC   = DEF_RST_CYC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     sel_load,
  input  logic [ADDR_W-1:0]        addr,
  output logic                     busy,
  output logic                     sel_valid,
  output logic [ADDR_W-1:0]        cur_addr,
  input  logic [IW_W-1:0]          iw,
  output logic [OW_W-1:0]          ow,
  output logic [NUM_PROJ-1:0]      proj_ena,
  output logic [NUM_PROJ-1:0]      proj_rst,
  output logic [NUM_PROJ*IW_W-1:0] proj_iw,
  input  logic [NUM_PROJ*OW_W-1:0] proj_ow
);

  state_t            state;
  logic [OW_W-1:0]   ow_q, ow_d;

  sel_mux_seq #(
    .NUM_PROJ  (NUM_PROJ),
    .ADDR_W    (ADDR_W),
    .GUARD_CYC (GUARD_CYC),
    .RST_CYC   (RST_CYC)
  ) u_seq (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .sel_load  (sel_load),
    .addr      (addr),
    .state     (state),
    .cur_addr  (cur_addr),
    .busy      (busy),
    .sel_valid (sel_valid)
  );

  // Only the slot matching cur_addr can ever light up, so enables stay one-hot-or-zero.
  always_comb begin
    proj_ena = '0;
    proj_rst = '0;
    proj_iw  = '0;
    ow_d     = '0;
    for (int k = 0; k < NUM_PROJ; k++) begin
      if (ena && (cur_addr == ADDR_W'(k))) begin
        if (state == PRST) begin
          proj_ena[k] = 1'b1;
          proj_rst[k] = 1'b1;
        end else if (state == ACTIVE) begin
          proj_ena[k]              = 1'b1;
          proj_iw[k*IW_W +: IW_W]  = iw;
          ow_d                     = proj_ow[k*OW_W +: OW_W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ow_q <= '0;
    end else begin
      ow_q <= ow_d;
    end
  end

  assign ow = ow_q;

endmodule

// File: tb/tb_sel_mux.sv
// Randomized self-checking bench for sel_mux against a timeline-based reference model.
module tb_sel_mux;

  localparam int NP  = 24;
  localparam int AW  = 5;
  localparam int IWW = 18;
  localparam int OWW = 24;
  localparam int GC  = 2;
  localparam int RC  = 3;
  localparam int CW  = NP * IWW;

  logic              clk = 1'b0;
  logic              rst;
  logic              ena;
  logic              sel_load;
  logic [AW-1:0]     addr;
  logic              busy;
  logic              sel_valid;
  logic [AW-1:0]     cur_addr;
  logic [IWW-1:0]    iw;
  logic [OWW-1:0]    ow;
  logic [NP-1:0]     proj_ena;
  logic [NP-1:0]     proj_rst;
  logic [NP*IWW-1:0] proj_iw;
  logic [NP*OWW-1:0] proj_ow;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a selection is "live" from its acceptance; its phase is
  // derived purely from how many cycles have elapsed since then.
  bit          m_live;
  int          m_elapsed;
  logic [AW-1:0]  m_cur;
  logic [OWW-1:0] m_ow;
  bit          fix5;
  logic        obs_busy;
  logic [NP-1:0] obs_ena;

  sel_mux #(
    .NUM_PROJ  (NP),
    .ADDR_W    (AW),
    .IW_W      (IWW),
    .OW_W      (OWW),
    .GUARD_CYC (GC),
    .RST_CYC   (RC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .sel_load  (sel_load),
    .addr      (addr),
    .busy      (busy),
    .sel_valid (sel_valid),
    .cur_addr  (cur_addr),
    .iw        (iw),
    .ow        (ow),
    .proj_ena  (proj_ena),
    .proj_rst  (proj_rst),
    .proj_iw   (proj_iw),
    .proj_ow   (proj_ow)
  );

  always #5 clk = ~clk;

  // 0 idle, 1 guard, 2 project reset, 3 active
  function automatic int modelPhase();
    if (!m_live) return 0;
    if (m_elapsed < GC) return 1;
    if (m_elapsed < GC + RC) return 2;
    return 3;
  endfunction

  task automatic checkOutput(input string tag, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic modelReset();
    m_live    = 1'b0;
    m_elapsed = 0;
    m_cur     = '0;
    m_ow      = '0;
  endtask

  task automatic checkAll();
    int p;
    logic [NP-1:0]     e_ena;
    logic [NP-1:0]     e_rst;
    logic [NP*IWW-1:0] e_iw;
    p     = modelPhase();
    e_ena = '0;
    e_rst = '0;
    e_iw  = '0;
    if (ena && (p == 2 || p == 3)) e_ena[m_cur] = 1'b1;
    if (ena && p == 2) e_rst[m_cur] = 1'b1;
    if (ena && p == 3) e_iw[int'(m_cur)*IWW +: IWW] = iw;
    checkOutput("busy", CW'(busy), CW'(p == 1 || p == 2));
    checkOutput("sel_valid", CW'(sel_valid), CW'(p == 3));
    checkOutput("cur_addr", CW'(cur_addr), CW'(m_cur));
    checkOutput("proj_ena", CW'(proj_ena), CW'(e_ena));
    checkOutput("proj_rst", CW'(proj_rst), CW'(e_rst));
    checkOutput("proj_iw", CW'(proj_iw), CW'(e_iw));
    checkOutput("ow", CW'(ow), CW'(m_ow));
    checkOutput("ena_onehot0", CW'($onehot0(proj_ena)), CW'(1));
  endtask

  task automatic modelStep();
    int p;
    p    = modelPhase();
    m_ow = (ena && p == 3) ? proj_ow[int'(m_cur)*OWW +: OWW] : '0;
    if (!ena) begin
      m_live = 1'b0;
    end else if (sel_load && (p == 0 || p == 3)) begin
      m_live    = 1'b1;
      m_elapsed = 0;
      m_cur     = addr;
    end else if (m_live) begin
      m_elapsed++;
      if (m_elapsed >= GC && int'(m_cur) >= NP) m_live = 1'b0;
    end
  endtask

  task automatic randomizeProjOw();
    for (int k = 0; k < NP; k++) proj_ow[k*OWW +: OWW] = OWW'($urandom);
    if (fix5) proj_ow[5*OWW +: OWW] = 24'hABCDEF;
  endtask

  task automatic applyStimulus(input logic e, input logic sl, input logic [AW-1:0] a);
    @(negedge clk);
    ena      = e;
    sel_load = sl;
    addr     = a;
    iw       = IWW'($urandom);
    randomizeProjOw();
    #1;
    checkAll();
    obs_busy = busy;
    obs_ena  = proj_ena;
    @(posedge clk);
    modelStep();
  endtask

  task automatic pulseReset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_busy", CW'(busy), CW'(0));
    checkOutput("rst_valid", CW'(sel_valid), CW'(0));
    checkOutput("rst_proj_ena", CW'(proj_ena), CW'(0));
    checkOutput("rst_proj_rst", CW'(proj_rst), CW'(0));
    checkOutput("rst_ow", CW'(ow), CW'(0));
    checkOutput("rst_cur_addr", CW'(cur_addr), CW'(0));
    modelReset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int cnt;
    rst      = 1'b1;
    ena      = 1'b0;
    sel_load = 1'b0;
    addr     = '0;
    iw       = '0;
    proj_ow  = '0;
    fix5     = 1'b1;
    modelReset();
    repeat (2) @(negedge clk);
    ena = 1'b1;
    #1;
    checkAll();
    @(negedge clk);
    rst = 1'b0;

    // Select slot 5: busy for guard plus reset window, then output follows slot 5.
    applyStimulus(1'b1, 1'b1, 5'd5);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 1'b0, 5'd0);
      if (obs_busy) cnt++;
    end
    checkOutput("busy_len", CW'(cnt), CW'(GC + RC));
    #1;
    checkOutput("ow_slot5", CW'(ow), CW'(24'hABCDEF));

    // Switch 5 -> 9: enables off for the guard window before slot 9 appears.
    applyStimulus(1'b1, 1'b1, 5'd9);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 5'd0);
      if (obs_ena == '0) cnt++;
    end
    checkOutput("switch_gap", CW'(cnt), CW'(GC));
    checkOutput("switch_slot9", CW'(obs_ena), CW'(24'h000200));

    // Out-of-range request ends idle but still reports the requested address.
    applyStimulus(1'b1, 1'b1, 5'd30);
    repeat (6) applyStimulus(1'b1, 1'b0, 5'd0);
    checkOutput("oor_cur_addr", CW'(cur_addr), CW'(30));

    // Drop ena while active.
    applyStimulus(1'b1, 1'b1, 5'd3);
    repeat (8) applyStimulus(1'b1, 1'b0, 5'd0);
    applyStimulus(1'b0, 1'b0, 5'd0);
    applyStimulus(1'b1, 1'b0, 5'd0);

    // Reset during the project reset window, then a load while busy is ignored.
    applyStimulus(1'b1, 1'b1, 5'd7);
    repeat (3) applyStimulus(1'b1, 1'b0, 5'd0);
    pulseReset();
    applyStimulus(1'b1, 1'b0, 5'd0);
    applyStimulus(1'b1, 1'b1, 5'd4);
    applyStimulus(1'b1, 1'b1, 5'd12);
    applyStimulus(1'b1, 1'b0, 5'd0);
    checkOutput("busy_ignore", CW'(cur_addr), CW'(4));
    repeat (6) applyStimulus(1'b1, 1'b0, 5'd0);

    // Random traffic.
    fix5 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) pulseReset();
      applyStimulus(($urandom_range(0, 19) != 0), ($urandom_range(0, 5) == 0),
                    AW'($urandom_range(0, 31)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
